vjtag_uart_fifo: RTL and testbench

- Buffering stage directly downstream/upstream of the VirtualJTAG byte link on the m_clock side.
- RX path: captures single-cycle recv strobes (with recv_data) into an RX FIFO; user logic drains it with a valid/ready handshake.
- TX path: user logic fills a TX FIFO; each send_ready pulse from the link is answered by a registered send strobe carrying the next byte.
- Decouples user logic from JTAG host timing; reports overflow/underflow as sticky flags.

---
 rtl/vjtag_uart_fifo.sv | 165 ++++++++++++++++
 tb/tb_vjtag_uart_fifo.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vjtag_uart_fifo.sv
// VirtualJTAG byte-link buffering stage.
// RX and TX byte FIFOs between the JTAG link and user logic.
module vjtag_uart_fifo #(
  parameter int         DEPTH_LOG2       = 4,
  parameter logic [7:0] FILL_BYTE        = 8'h00,
  parameter bit         RX_FLUSH_ON_INIT = 1'b0
) (
  input  logic                  m_clock,
  input  logic                  p_reset_n,
  input  logic                  recv_init,
  input  logic                  recv,
  input  logic [7:0]            recv_data,
  input  logic                  send_init,
  input  logic                  send_ready,
  output logic                  send,
  output logic [7:0]            send_data,
  output logic                  rx_valid,
  output logic [7:0]            rx_data,
  input  logic                  rx_ready,
  input  logic                  tx_valid,
  input  logic [7:0]            tx_data,
  output logic                  tx_ready,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic                  rx_overflow,
  output logic                  tx_underflow,
  input  logic                  clr_err
);

  localparam int AW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // RX FIFO state
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wr;
  logic [AW-1:0] rx_rd;
  logic [CW-1:0] rx_cnt;
  logic [AW-1:0] rx_waddr;
  logic          rx_flush;
  logic          rx_full;
  logic          rx_pop;
  logic          rx_push;
  logic          rx_ovf_evt;

  // TX FIFO state
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wr;
  logic [AW-1:0] tx_rd;
  logic [CW-1:0] tx_cnt;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_pop;
  logic          tx_push;
  logic          tx_unf_evt;

  // send_init carries no data; the link follows it with send_ready
  logic unused_send_init;
  assign unused_send_init = send_init;

  // A flush empties RX before this cycle's byte lands, so a pop is moot
  assign rx_flush   = RX_FLUSH_ON_INIT & recv_init;
  assign rx_full    = (rx_cnt == FULL_CNT);
  assign rx_valid   = (rx_cnt != '0);
  assign rx_pop     = rx_valid & rx_ready & ~rx_flush;
  assign rx_push    = recv & (rx_flush | ~rx_full | rx_pop);
  assign rx_ovf_evt = recv & ~rx_push;
  assign rx_waddr   = rx_flush ? '0 : rx_wr;
  assign rx_data    = rx_mem[rx_rd];
  assign rx_count   = rx_cnt;

  // Emptiness is sampled before this cycle's push
  assign tx_full    = (tx_cnt == FULL_CNT);
  assign tx_empty   = (tx_cnt == '0);
  assign tx_ready   = ~tx_full | send_ready;
  assign tx_push    = tx_valid & tx_ready;
  assign tx_pop     = send_ready & ~tx_empty;
  assign tx_unf_evt = send_ready & tx_empty;
  assign tx_count   = tx_cnt;

  // RX storage write
  always_ff @(posedge m_clock) begin
    if (rx_push)
      rx_mem[rx_waddr] <= recv_data;
  end

  // RX pointers and occupancy
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else if (rx_flush) begin
      rx_rd  <= '0;
      rx_wr  <= rx_push ? AW'(1) : '0;
      rx_cnt <= rx_push ? CW'(1) : '0;
    end else begin
      if (rx_push)
        rx_wr <= rx_wr + AW'(1);
      if (rx_pop)
        rx_rd <= rx_rd + AW'(1);
      unique case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // TX storage write
  always_ff @(posedge m_clock) begin
    if (tx_push)
      tx_mem[tx_wr] <= tx_data;
  end

  // TX pointers and occupancy
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push)
        tx_wr <= tx_wr + AW'(1);
      if (tx_pop)
        tx_rd <= tx_rd + AW'(1);
      unique case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // Answer each send_ready with a one-cycle send; data holds between sends
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      send      <= 1'b0;
      send_data <= 8'h00;
    end else begin
      send <= send_ready;
      if (send_ready)
        send_data <= tx_pop ? tx_mem[tx_rd] : FILL_BYTE;
    end
  end

  // Sticky error flags; a new event outranks clr_err
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      rx_overflow  <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      if (rx_ovf_evt)
        rx_overflow <= 1'b1;
      else if (clr_err)
        rx_overflow <= 1'b0;
      if (tx_unf_evt)
        tx_underflow <= 1'b1;
      else if (clr_err)
        tx_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vjtag_uart_fifo.sv
// Directed bench for vjtag_uart_fifo.
// Hand-computed expectations, default parameters.
module tb_vjtag_uart_fifo;

  logic       m_clock = 1'b0;
  logic       p_reset_n;
  logic       recv_init;
  logic       recv;
  logic [7:0] recv_data;
  logic       send_init;
  logic       send_ready;
  logic       send;
  logic [7:0] send_data;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [4:0] rx_count;
  logic [4:0] tx_count;
  logic       rx_overflow;
  logic       tx_underflow;
  logic       clr_err;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q[$];

  vjtag_uart_fifo dut (
    .m_clock      (m_clock),
    .p_reset_n    (p_reset_n),
    .recv_init    (recv_init),
    .recv         (recv),
    .recv_data    (recv_data),
    .send_init    (send_init),
    .send_ready   (send_ready),
    .send         (send),
    .send_data    (send_data),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .rx_count     (rx_count),
    .tx_count     (tx_count),
    .rx_overflow  (rx_overflow),
    .tx_underflow (tx_underflow),
    .clr_err      (clr_err)
  );

  always #5 m_clock = ~m_clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge m_clock);
    #1;
  endtask

  initial begin
    p_reset_n  = 1'b0;
    recv_init  = 1'b0;
    recv       = 1'b0;
    recv_data  = 8'h00;
    send_init  = 1'b0;
    send_ready = 1'b0;
    rx_ready   = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    clr_err    = 1'b0;
    repeat (3) tick();

    chk("rst_rx_count", 32'(rx_count), 0);
    chk("rst_tx_count", 32'(tx_count), 0);
    chk("rst_send", 32'(send), 0);
    chk("rst_send_data", 32'(send_data), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_ovf", 32'(rx_overflow), 0);
    chk("rst_unf", 32'(tx_underflow), 0);
    p_reset_n = 1'b1;
    tick();

    // RX: three bytes on separate cycles, then drain
    for (int i = 0; i < 3; i++) begin
      recv = 1'b1;
      recv_data = 8'h41 + 8'(i);
      tick();
      recv = 1'b0;
      tick();
    end
    chk("rx3_count", 32'(rx_count), 3);
    chk("rx3_valid", 32'(rx_valid), 1);
    chk("rx3_head", 32'(rx_data), 32'h41);
    for (int i = 0; i < 3; i++) begin
      chk("rx3_pop", 32'(rx_data), 32'h41 + i);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    chk("rx3_empty", 32'(rx_valid), 0);
    chk("rx3_cnt0", 32'(rx_count), 0);

    // RX overflow: 17 strobes, never popped
    q.delete();
    for (int i = 0; i < 17; i++) begin
      recv = 1'b1;
      recv_data = 8'(i);
      if (i < 16) q.push_back(8'(i));
      tick();
    end
    recv = 1'b0;
    chk("ovf_count", 32'(rx_count), 16);
    chk("ovf_flag", 32'(rx_overflow), 1);
    chk("ovf_head", 32'(rx_data), 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovf_clr", 32'(rx_overflow), 0);

    // RX full with simultaneous push and pop for 20 cycles
    for (int k = 0; k < 20; k++) begin
      chk("fullpp_head", 32'(rx_data), 32'(q[0]));
      recv = 1'b1;
      recv_data = 8'(100 + k);
      rx_ready = 1'b1;
      tick();
      void'(q.pop_front());
      q.push_back(8'(100 + k));
    end
    recv = 1'b0;
    rx_ready = 1'b0;
    chk("fullpp_count", 32'(rx_count), 16);
    chk("fullpp_ovf", 32'(rx_overflow), 0);
    for (int i = 0; i < 16; i++) begin
      chk("fullpp_drain", 32'(rx_data), 32'(q[i]));
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    chk("fullpp_empty", 32'(rx_valid), 0);

    // TX: two bytes, three send_ready pulses
    tx_valid = 1'b1;
    tx_data = 8'h55;
    tick();
    tx_data = 8'hAA;
    tick();
    tx_valid = 1'b0;
    chk("tx2_count", 32'(tx_count), 2);
    for (int i = 0; i < 3; i++) begin
      send_ready = 1'b1;
      tick();
      send_ready = 1'b0;
      chk("tx_send", 32'(send), 1);
      chk("tx_data", 32'(send_data),
          (i == 0) ? 32'h55 : (i == 1) ? 32'hAA : 32'h00);
      tick();
      chk("tx_send_low", 32'(send), 0);
      chk("tx_data_hold", 32'(send_data),
          (i == 0) ? 32'h55 : (i == 1) ? 32'hAA : 32'h00);
    end
    chk("tx_unf", 32'(tx_underflow), 1);
    chk("tx_cnt0", 32'(tx_count), 0);

    // Back-to-back send_ready
    tx_valid = 1'b1;
    tx_data = 8'h01;
    tick();
    tx_data = 8'h02;
    tick();
    tx_valid = 1'b0;
    send_ready = 1'b1;
    tick();
    chk("b2b_send1", 32'(send), 1);
    chk("b2b_data1", 32'(send_data), 32'h01);
    tick();
    send_ready = 1'b0;
    chk("b2b_send2", 32'(send), 1);
    chk("b2b_data2", 32'(send_data), 32'h02);
    tick();
    chk("b2b_low", 32'(send), 0);

    // clr_err with simultaneous underflow: flag stays set
    clr_err = 1'b1;
    send_ready = 1'b1;
    tick();
    clr_err = 1'b0;
    send_ready = 1'b0;
    chk("clr_vs_evt", 32'(tx_underflow), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("unf_clr", 32'(tx_underflow), 0);

    // TX empty: send_ready and push 0x7E together
    send_ready = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'h7E;
    tick();
    send_ready = 1'b0;
    tx_valid = 1'b0;
    chk("sp_send", 32'(send), 1);
    chk("sp_data", 32'(send_data), 32'h00);
    chk("sp_count", 32'(tx_count), 1);
    chk("sp_unf", 32'(tx_underflow), 1);
    tick();
    send_ready = 1'b1;
    tick();
    send_ready = 1'b0;
    chk("sp_next", 32'(send_data), 32'h7E);
    chk("sp_cnt0", 32'(tx_count), 0);

    // TX full: lone push ignored, push with send_ready accepted
    for (int i = 0; i < 16; i++) begin
      tx_valid = 1'b1;
      tx_data = 8'(8'h20 + i);
      tick();
    end
    tx_valid = 1'b0;
    chk("txf_count", 32'(tx_count), 16);
    chk("txf_ready", 32'(tx_ready), 0);
    tx_valid = 1'b1;
    tx_data = 8'hEE;
    tick();
    chk("txf_ignore", 32'(tx_count), 16);
    send_ready = 1'b1;
    tx_data = 8'hEF;
    tick();
    send_ready = 1'b0;
    tx_valid = 1'b0;
    chk("txf_pp_cnt", 32'(tx_count), 16);
    chk("txf_pp_data", 32'(send_data), 32'h20);

    // Reset mid-stream with RX half full and a send pulse live
    for (int i = 0; i < 8; i++) begin
      recv = 1'b1;
      recv_data = 8'(i);
      tick();
    end
    recv = 1'b0;
    send_ready = 1'b1;
    tick();
    send_ready = 1'b0;
    chk("pre_rst_rx", 32'(rx_count), 8);
    chk("pre_rst_send", 32'(send), 1);
    chk("pre_rst_unf", 32'(tx_underflow), 1);
    #2;
    p_reset_n = 1'b0;
    #1;
    chk("arst_rx_cnt", 32'(rx_count), 0);
    chk("arst_tx_cnt", 32'(tx_count), 0);
    chk("arst_send", 32'(send), 0);
    chk("arst_unf", 32'(tx_underflow), 0);
    chk("arst_ovf", 32'(rx_overflow), 0);
    chk("arst_rx_valid", 32'(rx_valid), 0);
    chk("arst_tx_ready", 32'(tx_ready), 1);
    chk("arst_sdata", 32'(send_data), 0);
    tick();
    p_reset_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
